// File: rtl/serial_receiver.sv
// 8N1 UART receiver with 16x oversampling, start-bit glitch rejection and a
// first-word-fall-through receive FIFO with sticky framing/overrun flags.
module serial_receiver #(
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     EN,
   input  logic [7:0]               BAUD_DIV,
   input  logic                     RX,
   input  logic                     RD,
   input  logic                     CLR,
   output logic [7:0]               DOUT,
   output logic                     EMPTY,
   output logic                     FULL,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     FRAME_ERR,
   output logic                     OVERRUN,
   output logic                     BUSY
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   logic          rx_meta_r, rxs_r;
   logic [7:0]    div_cnt_r, baud_r;
   logic          tick_s, div_clr_s;
   state_t        state_r, state_nxt_s;
   logic [3:0]    tick_cnt_r, tick_cnt_nxt_s;
   logic [2:0]    bit_idx_r, bit_idx_nxt_s;
   logic [7:0]    shift_r, shift_nxt_s;
   logic          push_s, fe_set_s, pop_s, wr_s, ovr_set_s;
   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wptr_r, rptr_r;
   logic [AW:0]   count_r, count_nxt_s;
   logic          empty_r, full_r, frame_err_r, overrun_r;

   // Two-flop synchronizer for the asynchronous line, idling high.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_meta_r <= 1'b1;
         rxs_r     <= 1'b1;
      end else begin
         rx_meta_r <= RX;
         rxs_r     <= rx_meta_r;
      end
   end

   // The divisor is latched only at a wrap so a change never truncates a tick period.
   assign tick_s = (div_cnt_r == baud_r);

   // Oversample divider; restarted on start-bit detection for phase alignment.
   always_ff @(posedge CLK) begin
      if (RST) begin
         div_cnt_r <= 8'd0;
         baud_r    <= 8'd0;
      end else if (div_clr_s || tick_s) begin
         div_cnt_r <= 8'd0;
         baud_r    <= BAUD_DIV;
      end else begin
         div_cnt_r <= div_cnt_r + 8'd1;
      end
   end

   // Frame state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r    <= IDLE;
         tick_cnt_r <= 4'd0;
         bit_idx_r  <= 3'd0;
         shift_r    <= 8'd0;
      end else begin
         state_r    <= state_nxt_s;
         tick_cnt_r <= tick_cnt_nxt_s;
         bit_idx_r  <= bit_idx_nxt_s;
         shift_r    <= shift_nxt_s;
      end
   end

   // Next-state logic: start check at mid-bit, data and stop sampled every 16 ticks.
   always_comb begin
      state_nxt_s    = state_r;
      tick_cnt_nxt_s = tick_cnt_r;
      bit_idx_nxt_s  = bit_idx_r;
      shift_nxt_s    = shift_r;
      div_clr_s      = 1'b0;
      push_s         = 1'b0;
      fe_set_s       = 1'b0;
      if (!EN) begin
         state_nxt_s    = IDLE;
         tick_cnt_nxt_s = 4'd0;
         bit_idx_nxt_s  = 3'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (!rxs_r) begin
                  state_nxt_s    = START;
                  tick_cnt_nxt_s = 4'd0;
                  bit_idx_nxt_s  = 3'd0;
                  div_clr_s      = 1'b1;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            START: begin
               if (tick_s && (tick_cnt_r == 4'd7)) begin
                  tick_cnt_nxt_s = 4'd0;
                  if (!rxs_r) begin
                     state_nxt_s = DATA;
                  end else begin
                     state_nxt_s = IDLE;
                  end
               end else if (tick_s) begin
                  tick_cnt_nxt_s = tick_cnt_r + 4'd1;
               end else begin
                  state_nxt_s = START;
               end
            end
            DATA: begin
               if (tick_s && (tick_cnt_r == 4'd15)) begin
                  tick_cnt_nxt_s         = 4'd0;
                  shift_nxt_s[bit_idx_r] = rxs_r;
                  if (bit_idx_r == 3'd7) begin
                     state_nxt_s   = STOP;
                     bit_idx_nxt_s = 3'd0;
                  end else begin
                     bit_idx_nxt_s = bit_idx_r + 3'd1;
                  end
               end else if (tick_s) begin
                  tick_cnt_nxt_s = tick_cnt_r + 4'd1;
               end else begin
                  state_nxt_s = DATA;
               end
            end
            STOP: begin
               if (tick_s && (tick_cnt_r == 4'd15)) begin
                  tick_cnt_nxt_s = 4'd0;
                  if (rxs_r) begin
                     push_s      = 1'b1;
                     state_nxt_s = IDLE;
                  end else begin
                     fe_set_s    = 1'b1;
                     state_nxt_s = WAIT_HIGH;
                  end
               end else if (tick_s) begin
                  tick_cnt_nxt_s = tick_cnt_r + 4'd1;
               end else begin
                  state_nxt_s = STOP;
               end
            end
            WAIT_HIGH: begin
               if (rxs_r) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = WAIT_HIGH;
               end
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end
   end

   // A push into a full FIFO succeeds only when a pop frees the slot in the same cycle.
   assign pop_s     = RD && !empty_r;
   assign wr_s      = push_s && (!full_r || pop_s);
   assign ovr_set_s = push_s && full_r && !pop_s;

   // Occupancy bookkeeping for simultaneous push/pop.
   always_comb begin
      count_nxt_s = count_r;
      if (wr_s && !pop_s) begin
         count_nxt_s = count_r + CNT_ONE;
      end else if (pop_s && !wr_s) begin
         count_nxt_s = count_r - CNT_ONE;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // FIFO pointers, occupancy and status flags.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
         empty_r <= 1'b1;
         full_r  <= 1'b0;
      end else begin
         if (wr_s) wptr_r <= wptr_r + PTR_ONE;
         if (pop_s) rptr_r <= rptr_r + PTR_ONE;
         count_r <= count_nxt_s;
         empty_r <= (count_nxt_s == '0);
         full_r  <= (count_nxt_s == FULL_LVL);
      end
   end

   // FIFO storage is deliberately left unreset.
   always_ff @(posedge CLK) begin
      if (!RST && wr_s) mem_r[wptr_r] <= shift_r;
   end

   // Sticky error flags; a coincident set beats CLR.
   always_ff @(posedge CLK) begin
      if (RST) begin
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         if (fe_set_s) frame_err_r <= 1'b1;
         else if (CLR) frame_err_r <= 1'b0;
         if (ovr_set_s) overrun_r <= 1'b1;
         else if (CLR) overrun_r <= 1'b0;
      end
   end

   assign DOUT      = mem_r[rptr_r];
   assign EMPTY     = empty_r;
   assign FULL      = full_r;
   assign COUNT     = count_r;
   assign FRAME_ERR = frame_err_r;
   assign OVERRUN   = overrun_r;
   assign BUSY      = (state_r != IDLE);

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: each task drives one scenario and checks
// the outputs against hand-computed values on the falling clock edge.
module tb_serial_receiver;

   logic       CLK = 1'b0;
   logic       RST, EN, RX, RD, CLR;
   logic [7:0] BAUD_DIV;
   logic [7:0] DOUT;
   logic       EMPTY, FULL, FRAME_ERR, OVERRUN, BUSY;
   logic [2:0] COUNT;
   int         checks = 0;
   int         failures = 0;
   logic       pre_empty, post_empty;

   always #5 CLK = ~CLK;

   serial_receiver #(.DEPTH(4)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .BAUD_DIV(BAUD_DIV), .RX(RX), .RD(RD),
      .CLR(CLR), .DOUT(DOUT), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT),
      .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN), .BUSY(BUSY)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at a falling edge; one bit lasts bl clocks. With bl=16 the stop
   // sample edge is the 11th rising edge of the stop bit, so iteration 10 is
   // the push cycle.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_push, input int bl);
      RX = 1'b0;
      repeat (bl) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (bl) @(negedge CLK);
      end
      RX = stop;
      for (int i = 0; i < bl; i++) begin
         if (i == 10) pre_empty = EMPTY;
         if (i == 11) post_empty = EMPTY;
         RD = (rd_push && (i == 10));
         @(negedge CLK);
      end
      RD = 1'b0;
      RX = 1'b1;
      repeat (4) @(negedge CLK);
   endtask

   task automatic pop_byte(input logic [7:0] exp, input string name);
      checks++; if (DOUT !== exp) begin failures++; $display("FAIL %s dout got=%h exp=%h", name, DOUT, exp); end
      RD = 1'b1;
      @(negedge CLK);
      RD = 1'b0;
   endtask

   task automatic test_reset;
      RST = 1'b1; EN = 1'b1; RX = 1'b1; RD = 1'b0; CLR = 1'b0; BAUD_DIV = 8'd0;
      repeat (3) @(negedge CLK);
      checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", EMPTY); end
      checks++; if (FULL !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", FULL); end
      checks++; if (COUNT !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
      checks++; if ({FRAME_ERR, OVERRUN, BUSY} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {FRAME_ERR, OVERRUN, BUSY}); end
      RST = 1'b0;
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_basic;
      send_frame(8'hA5, 1'b1, 1'b0, 16);
      checks++; if (pre_empty !== 1'b1) begin failures++; $display("FAIL basic_empty_before got=%b exp=1", pre_empty); end
      checks++; if (post_empty !== 1'b0) begin failures++; $display("FAIL basic_empty_after got=%b exp=0", post_empty); end
      checks++; if (COUNT !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", COUNT); end
      pop_byte(8'hA5, "basic");
      checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL basic_pop_empty got=%b exp=1", EMPTY); end
      RD = 1'b1; @(negedge CLK); RD = 1'b0; @(negedge CLK);
      checks++; if ({COUNT, EMPTY} !== {3'd0, 1'b1}) begin failures++; $display("FAIL rd_empty got=%0d/%b exp=0/1", COUNT, EMPTY); end
   endtask

   task automatic test_glitch;
      RX = 1'b0;
      repeat (4) @(negedge CLK);
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL glitch_busy got=%b exp=1", BUSY); end
      RX = 1'b1;
      repeat (20) @(negedge CLK);
      checks++; if ({BUSY, FRAME_ERR, COUNT} !== {1'b0, 1'b0, 3'd0}) begin failures++; $display("FAIL glitch_idle got=%b/%b/%0d exp=0/0/0", BUSY, FRAME_ERR, COUNT); end
   endtask

   task automatic test_frame_error;
      send_frame(8'h3C, 1'b0, 1'b0, 16);
      checks++; if (FRAME_ERR !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b exp=1", FRAME_ERR); end
      checks++; if (COUNT !== 3'd0) begin failures++; $display("FAIL ferr_count got=%0d exp=0", COUNT); end
      CLR = 1'b1; @(negedge CLK); CLR = 1'b0;
      checks++; if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL ferr_clr got=%b exp=0", FRAME_ERR); end
   endtask

   task automatic test_break;
      RX = 1'b0;
      repeat (200) @(negedge CLK);
      checks++; if ({FRAME_ERR, BUSY} !== 2'b11) begin failures++; $display("FAIL break_err got=%b exp=11", {FRAME_ERR, BUSY}); end
      CLR = 1'b1; @(negedge CLK); CLR = 1'b0;
      repeat (200) @(negedge CLK);
      checks++; if ({FRAME_ERR, COUNT} !== {1'b0, 3'd0}) begin failures++; $display("FAIL break_repeat got=%b/%0d exp=0/0", FRAME_ERR, COUNT); end
      RX = 1'b1;
      repeat (5) @(negedge CLK);
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL break_release got=%b exp=0", BUSY); end
   endtask

   task automatic test_enable;
      send_frame(8'h42, 1'b1, 1'b0, 16);
      RX = 1'b0;
      repeat (40) @(negedge CLK);
      EN = 1'b0;
      @(negedge CLK);
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL en_abort got=%b exp=0", BUSY); end
      RX = 1'b1;
      repeat (5) @(negedge CLK);
      EN = 1'b1;
      checks++; if ({COUNT, FRAME_ERR} !== {3'd1, 1'b0}) begin failures++; $display("FAIL en_fifo got=%0d/%b exp=1/0", COUNT, FRAME_ERR); end
      pop_byte(8'h42, "en_keep");
   endtask

   task automatic test_overrun;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 16);
      checks++; if ({COUNT, FULL, OVERRUN} !== {3'd4, 1'b1, 1'b0}) begin failures++; $display("FAIL fill got=%0d/%b/%b exp=4/1/0", COUNT, FULL, OVERRUN); end
      send_frame(8'h05, 1'b1, 1'b0, 16);
      checks++; if ({COUNT, OVERRUN} !== {3'd4, 1'b1}) begin failures++; $display("FAIL overrun got=%0d/%b exp=4/1", COUNT, OVERRUN); end
      pop_byte(8'h01, "ovr_rd1");
      pop_byte(8'h02, "ovr_rd2");
      pop_byte(8'h03, "ovr_rd3");
      pop_byte(8'h04, "ovr_rd4");
      checks++; if ({EMPTY, COUNT} !== {1'b1, 3'd0}) begin failures++; $display("FAIL ovr_drain got=%b/%0d exp=1/0", EMPTY, COUNT); end
      CLR = 1'b1; @(negedge CLK); CLR = 1'b0;
      checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", OVERRUN); end
   endtask

   task automatic test_back_to_back;
      send_frame(8'h11, 1'b1, 1'b0, 16);
      send_frame(8'h22, 1'b1, 1'b0, 16);
      send_frame(8'h33, 1'b1, 1'b0, 16);
      send_frame(8'h44, 1'b1, 1'b0, 16);
      send_frame(8'h55, 1'b1, 1'b1, 16);
      checks++; if ({COUNT, FULL, OVERRUN} !== {3'd4, 1'b1, 1'b0}) begin failures++; $display("FAIL full_rw got=%0d/%b/%b exp=4/1/0", COUNT, FULL, OVERRUN); end
      pop_byte(8'h22, "rw_rd1");
      pop_byte(8'h33, "rw_rd2");
      pop_byte(8'h44, "rw_rd3");
      pop_byte(8'h55, "rw_rd4");
      checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL rw_drain got=%b exp=1", EMPTY); end
   endtask

   task automatic test_baud;
      BAUD_DIV = 8'd1;
      repeat (4) @(negedge CLK);
      send_frame(8'h5A, 1'b1, 1'b0, 32);
      checks++; if (COUNT !== 3'd1) begin failures++; $display("FAIL baud_count got=%0d exp=1", COUNT); end
      pop_byte(8'h5A, "baud");
      BAUD_DIV = 8'd0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic test_reset_mid;
      send_frame(8'h3C, 1'b0, 1'b0, 16);
      send_frame(8'h77, 1'b1, 1'b0, 16);
      RX = 1'b0; repeat (16) @(negedge CLK);
      RX = 1'b1; repeat (30) @(negedge CLK);
      checks++; if ({BUSY, FRAME_ERR, COUNT} !== {1'b1, 1'b1, 3'd1}) begin failures++; $display("FAIL mid_pre got=%b/%b/%0d exp=1/1/1", BUSY, FRAME_ERR, COUNT); end
      RST = 1'b1;
      @(negedge CLK);
      checks++; if ({BUSY, EMPTY, FULL, FRAME_ERR, OVERRUN, COUNT} !== {5'b01000, 3'd0}) begin failures++; $display("FAIL mid_reset got=%b%b%b%b%b/%0d exp=01000/0", BUSY, EMPTY, FULL, FRAME_ERR, OVERRUN, COUNT); end
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      send_frame(8'h81, 1'b1, 1'b0, 16);
      checks++; if (COUNT !== 3'd1) begin failures++; $display("FAIL mid_next_count got=%0d exp=1", COUNT); end
      pop_byte(8'h81, "mid_next");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_error();
      test_break();
      test_enable();
      test_overrun();
      test_back_to_back();
      test_baud();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have parameter DEPTH, default 4: receive FIFO depth in bytes, power of two, 2..16.
REQ-002 SHALL have ports in this order:
- CLK  input  1  sole clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- EN  input  1  receiver enable.
- BAUD_DIV  input  8  oversample divisor; tick period = BAUD_DIV+1 clocks.
- RX  input  1  asynchronous serial line, idle high.
- RD  input  1  pop strobe, one byte per asserted cycle.
- CLR  input  1  clears sticky error flags.
- DOUT  output  8  FIFO head byte.
- EMPTY  output  1  FIFO empty.
- FULL  output  1  FIFO full.
- COUNT  output  $clog2(DEPTH)+1  FIFO occupancy.
- FRAME_ERR  output  1  sticky framing error.
- OVERRUN  output  1  sticky overrun.
- BUSY  output  1  frame in progress (state not IDLE).

Function
REQ-003 SHALL pass RX through a 2-flop synchronizer; all logic uses the synchronized value RXS.
REQ-004 SHALL generate a one-cycle tick when the divide counter equals BAUD_DIV, then wrap to 0; BAUD_DIV=0 gives a tick every clock.
REQ-005 SHALL use 16 ticks per bit, 8N1 format, LSB first.
REQ-006 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-007 IDLE: on RXS=0 with EN=1, enter START and clear the divide and tick counters the same cycle (phase alignment).
REQ-008 START: at the 8th tick, if RXS=0 enter DATA with tick count 0; if RXS=1 treat as a glitch and return to IDLE with no flags changed.
REQ-009 DATA: sample RXS at each 16th tick into bit index 0..7; after bit 7 enter STOP.
REQ-010 STOP: at the 16th tick, if RXS=1 push the byte and enter IDLE; if RXS=0 set FRAME_ERR, discard the byte, and enter WAIT_HIGH.
REQ-011 WAIT_HIGH: remain until RXS=1, then enter IDLE; a held-low line (break) SHALL produce exactly one FRAME_ERR and no repeated frames.
REQ-012 EN=0 SHALL force IDLE the next cycle, abandon any partial frame, and leave FIFO contents intact.
REQ-013 The FIFO SHALL be first-word-fall-through: DOUT = head byte combinationally; DOUT is don't-care when EMPTY=1.
REQ-014 RD while EMPTY=1 SHALL be ignored, with no pointer or COUNT change.
REQ-015 A push SHALL take effect on the cycle after the stop-bit sample; COUNT, EMPTY and FULL update on that edge.
REQ-016 A push while FULL with no RD the same cycle SHALL drop the byte and set OVERRUN.
REQ-017 Push and RD in the same cycle while FULL SHALL both succeed: COUNT unchanged, OVERRUN not set.
REQ-018 Push and RD in the same cycle while non-full and non-empty SHALL leave COUNT unchanged.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; COUNT ranges 0..DEPTH.
REQ-020 CLR SHALL clear FRAME_ERR and OVERRUN; if a set event coincides with CLR, set wins.
REQ-021 BAUD_DIV changes take effect at the next counter wrap.

Reset
REQ-022 RST SHALL override all other inputs, including mid-frame.
REQ-023 On RST: state IDLE, counters 0, pointers 0, COUNT=0, EMPTY=1, FULL=0, FRAME_ERR=0, OVERRUN=0, BUSY=0; synchronizer flops = 1.
REQ-024 DOUT SHALL be don't-care after reset (FIFO storage is not reset).

Verification
REQ-025 BAUD_DIV=0, 1 bit = 16 CLK: send 0xA5 -> EMPTY falls one cycle after stop sample; DOUT=0xA5; COUNT=1; pulse RD -> EMPTY=1.
REQ-026 RX low for 4 ticks then high -> no push, FRAME_ERR=0, BUSY returns to 0.
REQ-027 Send 0x3C with stop bit 0 and line then high -> FRAME_ERR=1, COUNT=0; CLR -> FRAME_ERR=0.
REQ-028 Send 0x01..0x05 with no reads, DEPTH=4 -> COUNT=4, FULL=1, OVERRUN=1; read sequence 0x01..0x04.
REQ-029 FIFO full; assert RD on the push cycle of byte 0x55 -> COUNT stays 4, OVERRUN=0; 0x55 is read last.
REQ-030 RST mid DATA state -> all outputs at reset values next cycle; next frame 0x81 is received correctly.
